// File: rtl/alu_muldiv_unit.sv
// Execute-stage unit for the nanoMIPS core: combinational ALU (4-bit ALUctr) plus a
// sequential one-bit-per-cycle multiply/divide engine owning the HI/LO registers.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUctr,
    output logic [WIDTH-1:0] RES,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             CPR_RES,
    input  logic [1:0]       MD_op,
    input  logic             MD_start,
    output logic             MD_busy,
    output logic             MD_done,
    input  logic             HILO_we,
    input  logic             HILO_sel,
    input  logic [WIDTH-1:0] HILO_wdata,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // ---------------- combinational ALU ----------------
    logic [WIDTH-1:0] a_eff, b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_out, carry_msb_in, ovf, lt;

    always_comb begin
        if (ALUctr[1]) begin
            a_eff = cond_neg(A, ALUctr[3]);
            b_eff = cond_neg(B, ALUctr[2]);
        end else begin
            a_eff = ALUctr[3] ? ~A : A;
            b_eff = ALUctr[2] ? ~B : B;
        end
    end

    assign sum          = {1'b0, a_eff} + {1'b0, b_eff};
    assign carry_out    = sum[WIDTH];
    assign carry_msb_in = sum[WIDTH-1] ^ a_eff[WIDTH-1] ^ b_eff[WIDTH-1];
    assign ovf          = carry_out ^ carry_msb_in;
    // Sign of the sum corrected by overflow gives the true signed compare
    assign lt           = sum[WIDTH-1] ^ ovf;

    always_comb begin
        RES = '0;
        case (ALUctr[1:0])
            2'b00:   RES = a_eff & b_eff;
            2'b01:   RES = a_eff | b_eff;
            2'b10:   RES = sum[WIDTH-1:0];
            default: RES = {{(WIDTH-1){1'b0}}, lt};
        endcase
    end

    assign Zero     = (RES == '0);
    assign Carry    = ALUctr[1] & carry_out;
    assign Overflow = ALUctr[1] & ovf;
    assign CPR_RES  = (ALUctr[1:0] == 2'b11) & lt;

    // ---------------- multiply/divide engine ----------------
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic             sign_a_q, sign_b_q;
    logic [WIDTH-1:0] a_orig_q, opb_q, acc_hi_q, acc_lo_q, hi_q, lo_q;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic             a_neg, b_neg, start_acc, last_iter;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign a_s       = A;
    assign b_s       = B;
    assign a_neg     = MD_op[0] && (a_s < 0);
    assign b_neg     = MD_op[0] && (b_s < 0);
    assign abs_a     = cond_neg(A, a_neg);
    assign abs_b     = cond_neg(B, b_neg);
    assign start_acc = MD_start && (state_q != S_RUN);
    assign last_iter = (state_q == S_RUN) && (cnt_q == LAST);

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] product;
    logic               q_neg;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (op_q[1]) begin
            // Restoring step: keep the shifted remainder when the trial subtract borrows
            nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        q_neg   = op_q[0] & (sign_a_q ^ sign_b_q);
        product = cond_neg2({nxt_hi, nxt_lo}, q_neg);
        fin_hi  = product[2*WIDTH-1:WIDTH];
        fin_lo  = product[WIDTH-1:0];
        if (op_q[1]) begin
            if (opb_q == '0) begin
                fin_hi = a_orig_q;
                fin_lo = '1;
            end else begin
                fin_hi = cond_neg(nxt_hi, op_q[0] & sign_a_q);
                fin_lo = cond_neg(nxt_lo, q_neg);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        MD_busy = 1'b0;
        MD_done = 1'b0;
        case (state_q)
            S_IDLE: if (MD_start) state_d = S_RUN;
            S_RUN: begin
                MD_busy = 1'b1;
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                MD_done = 1'b1;
                state_d = MD_start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_orig_q <= '0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (start_acc) begin
                op_q     <= MD_op;
                sign_a_q <= a_neg;
                sign_b_q <= b_neg;
                a_orig_q <= A;
                opb_q    <= abs_b;
                acc_hi_q <= '0;
                acc_lo_q <= abs_a;
                cnt_q    <= '0;
            end else if (state_q == S_RUN) begin
                acc_hi_q <= nxt_hi;
                acc_lo_q <= nxt_lo;
                cnt_q    <= cnt_q + CW'(1);
            end
            // Commit and direct writes never coincide: writes are only taken when not running
            if (last_iter) begin
                hi_q <= fin_hi;
                lo_q <= fin_lo;
            end else if (HILO_we && (state_q != S_RUN)) begin
                if (HILO_sel) hi_q <= HILO_wdata;
                else          lo_q <= HILO_wdata;
            end
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit: ALU flags, MULT/DIV timing and
// results, divide-by-zero, HI/LO direct writes and reset abort.
module tb_alu_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B, RES, HILO_wdata, HI, LO;
    logic [3:0]   ALUctr;
    logic         Zero, Carry, Overflow, CPR_RES;
    logic [1:0]   MD_op;
    logic         MD_start, MD_busy, MD_done, HILO_we, HILO_sel;

    int tests_run = 0;
    int tests_failed = 0;

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUctr(ALUctr), .RES(RES),
        .Zero(Zero), .Carry(Carry), .Overflow(Overflow), .CPR_RES(CPR_RES),
        .MD_op(MD_op), .MD_start(MD_start), .MD_busy(MD_busy), .MD_done(MD_done),
        .HILO_we(HILO_we), .HILO_sel(HILO_sel), .HILO_wdata(HILO_wdata),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start that is sampled at the next edge (E0), then scramble operands
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        MD_op = op; A = a; B = b; MD_start = 1'b1;
        step();
        MD_start = 1'b0;
        A = $urandom; B = $urandom; MD_op = 2'($urandom_range(0, 3));
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; A = '0; B = '0; ALUctr = 4'b0000; MD_op = 2'b00; MD_start = 1'b0;
        HILO_we = 1'b0; HILO_sel = 1'b0; HILO_wdata = '0;
        step(); step();
        chk32("rst_hi", HI, 32'h0);
        chk32("rst_lo", LO, 32'h0);
        chk1("rst_busy", MD_busy, 1'b0);
        chk1("rst_done", MD_done, 1'b0);
        rst_n = 1'b1;
        step();

        // ALU vectors
        A = 32'h7FFFFFFF; B = 32'h00000001; ALUctr = 4'b0010; #1;
        chk32("add_res", RES, 32'h80000000);
        chk1("add_ovf", Overflow, 1'b1);
        chk1("add_carry", Carry, 1'b0);
        chk1("add_zero", Zero, 1'b0);
        A = 32'h80000000; B = 32'h00000001; ALUctr = 4'b0111; #1;
        chk32("slt_ovf_res", RES, 32'h00000001);
        chk1("slt_ovf_cpr", CPR_RES, 1'b1);
        chk1("slt_ovf_ovf", Overflow, 1'b1);
        chk1("slt_ovf_carry", Carry, 1'b1);
        A = 32'hF0F0F0F0; B = 32'h0F0F0F0F; ALUctr = 4'b0000; #1;
        chk32("and_res", RES, 32'h0);
        chk1("and_zero", Zero, 1'b1);
        chk1("and_carry", Carry, 1'b0);
        A = 32'h00000000; B = 32'hFFFF0000; ALUctr = 4'b0101; #1;
        chk32("or_binv_res", RES, 32'h0000FFFF);
        A = 32'h00000005; B = 32'h00000005; ALUctr = 4'b0110; #1;
        chk32("sub_res", RES, 32'h0);
        chk1("sub_zero", Zero, 1'b1);
        chk1("sub_carry", Carry, 1'b1);
        chk1("sub_ovf", Overflow, 1'b0);
        A = 32'h00000001; B = 32'h00000002; ALUctr = 4'b0111; #1;
        chk32("slt_res", RES, 32'h00000001);
        chk1("slt_cpr", CPR_RES, 1'b1);
        A = 32'h00000002; B = 32'h00000001; ALUctr = 4'b0111; #1;
        chk32("slt_false_res", RES, 32'h0);
        chk1("slt_false_cpr", CPR_RES, 1'b0);
        A = 32'hF0000000; B = 32'h0F000000; ALUctr = 4'b1100; #1;
        chk32("nor_res", RES, 32'h00FFFFFF);
        chk1("nor_ovf", Overflow, 1'b0);

        // MULT -2 * 3 with an ignored restart at E5
        start_op(2'b01, 32'hFFFFFFFE, 32'h00000003);
        chk1("mult_busy_e0", MD_busy, 1'b1);
        repeat (4) step();
        MD_start = 1'b1; MD_op = 2'b10; A = 32'h00000064; B = 32'h00000007;
        step();
        MD_start = 1'b0;
        chk1("mult_busy_e5", MD_busy, 1'b1);
        repeat (W - 1 - 5) step();
        chk1("mult_busy_e31", MD_busy, 1'b1);
        chk1("mult_done_e31", MD_done, 1'b0);
        chk32("mult_hi_e31", HI, 32'h0);
        step();
        chk1("mult_busy_e32", MD_busy, 1'b0);
        chk1("mult_done_e32", MD_done, 1'b1);
        chk32("mult_hi", HI, 32'hFFFFFFFF);
        chk32("mult_lo", LO, 32'hFFFFFFFA);
        step();
        chk1("mult_done_e33", MD_done, 1'b0);
        chk1("mult_busy_e33", MD_busy, 1'b0);

        // DIV -7 / 2, then back-to-back most-negative / -1 issued in the DONE cycle
        start_op(2'b11, 32'hFFFFFFF9, 32'h00000002);
        repeat (W - 1) step();
        step();
        chk1("div_done", MD_done, 1'b1);
        chk32("div_lo", LO, 32'hFFFFFFFD);
        chk32("div_hi", HI, 32'hFFFFFFFF);
        start_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
        chk1("div2_busy_rerise", MD_busy, 1'b1);
        chk1("div2_done_low", MD_done, 1'b0);
        repeat (W - 1) step();
        step();
        chk1("div2_done", MD_done, 1'b1);
        chk32("div2_lo", LO, 32'h80000000);
        chk32("div2_hi", HI, 32'h0);

        // DIVU by zero with a dropped write during RUN
        start_op(2'b10, 32'h00001234, 32'h00000000);
        HILO_we = 1'b1; HILO_sel = 1'b0; HILO_wdata = 32'hDEADBEEF;
        step();
        HILO_we = 1'b0;
        chk32("busy_write_dropped", LO, 32'h80000000);
        repeat (W - 2) step();
        step();
        chk1("divz_done", MD_done, 1'b1);
        chk32("divz_hi", HI, 32'h00001234);
        chk32("divz_lo", LO, 32'hFFFFFFFF);
        HILO_we = 1'b1; HILO_sel = 1'b1; HILO_wdata = 32'hA5A5A5A5;
        step();
        HILO_we = 1'b0;
        chk32("mthi_hi", HI, 32'hA5A5A5A5);
        chk32("mthi_lo_kept", LO, 32'hFFFFFFFF);
        HILO_we = 1'b1; HILO_sel = 1'b0; HILO_wdata = 32'h12345678;
        step();
        HILO_we = 1'b0;
        chk32("mtlo_lo", LO, 32'h12345678);
        chk32("mtlo_hi_kept", HI, 32'hA5A5A5A5);

        // Direct write accepted together with a start; the commit overwrites it later
        HILO_we = 1'b1; HILO_sel = 1'b0; HILO_wdata = 32'hCAFEF00D;
        start_op(2'b00, 32'h00000003, 32'h00000005);
        HILO_we = 1'b0;
        chk32("simul_lo_written", LO, 32'hCAFEF00D);
        chk1("simul_busy", MD_busy, 1'b1);
        repeat (W - 1) step();
        step();
        chk32("multu_small_hi", HI, 32'h0);
        chk32("multu_small_lo", LO, 32'h0000000F);

        // Reset in the middle of a MULTU
        HILO_we = 1'b1; HILO_sel = 1'b1; HILO_wdata = 32'h55AA55AA;
        step();
        HILO_we = 1'b0;
        start_op(2'b00, 32'h0000FFFF, 32'h0000FFFF);
        repeat (9) step();
        #2 rst_n = 1'b0;
        #1;
        chk1("abort_busy", MD_busy, 1'b0);
        chk1("abort_done", MD_done, 1'b0);
        chk32("abort_hi", HI, 32'h0);
        chk32("abort_lo", LO, 32'h0);
        step(); step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (MD_done || MD_busy) saw_done = 1'b1;
        end
        chk1("abort_no_activity", saw_done, 1'b0);
        chk32("abort_lo_held", LO, 32'h0);

        // MULTU full-scale after recovery
        start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (W - 1) step();
        step();
        chk1("multu_done", MD_done, 1'b1);
        chk32("multu_hi", HI, 32'hFFFFFFFE);
        chk32("multu_lo", LO, 32'h00000001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
